// File: rtl/onion_wb_master.sv
// onion_wb_master: single-outstanding command to Wishbone initiator bridge.
// Accepts one command, runs one classic Wishbone cycle, returns one response.
//
// Ports:
//   WBs_CLK_i, WBs_RST_n_i          clock, async active-low reset
//   cmd_valid_i/cmd_ready_o         command handshake
//   cmd_we_i, cmd_adr_i[16:0]       write flag, byte address
//   cmd_sel_i[3:0], cmd_dat_i[31:0] byte strobes, write data
//   rsp_valid_o/rsp_ready_i         response handshake
//   rsp_dat_o[31:0], rsp_err_o      read data, timeout flag
//   WBm_*                           Wishbone initiator bus
//
// Build option: define ONION_WB_MASTER_TIMEOUT_EN to compile in the ACK
// timeout (TIMEOUT_CYCLES, ERR_READ_VALUE). Without it the bus cycle waits
// for ACK indefinitely and rsp_err_o is constant 0.

module onion_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_READ_VALUE = 32'hDEAD_BEEF
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_n_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [16:0] cmd_adr_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_dat_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic [16:0] WBm_ADR_o,
    output logic        WBm_CYC_o,
    output logic        WBm_STB_o,
    output logic        WBm_WE_o,
    output logic [3:0]  WBm_BYTE_STB_o,
    output logic [31:0] WBm_DAT_o,
    input  logic [31:0] WBm_DAT_i,
    input  logic        WBm_ACK_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        cmd_ready_d;
    logic        cyc_d;
    logic        stb_d;
    logic        we_d;
    logic [16:0] adr_d;
    logic [3:0]  sel_d;
    logic [31:0] wdat_d;
    logic        rsp_valid_d;
    logic [31:0] rsp_dat_d;

`ifdef ONION_WB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rsp_err_d;
    logic             tmo_hit;

    assign tmo_hit = (cnt_q == CNT_LAST);
`else
    // Parameters stay on the interface so both builds share one port map.
    logic unused_cfg;

    assign unused_cfg = ^{ERR_READ_VALUE, TIMEOUT_CYCLES[0]};
    assign rsp_err_o  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_o;
        cyc_d       = WBm_CYC_o;
        stb_d       = WBm_STB_o;
        we_d        = WBm_WE_o;
        adr_d       = WBm_ADR_o;
        sel_d       = WBm_BYTE_STB_o;
        wdat_d      = WBm_DAT_o;
        rsp_valid_d = rsp_valid_o;
        rsp_dat_d   = rsp_dat_o;
`ifdef ONION_WB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_o;
`endif

        unique case (state_q)
            IDLE: begin
                // Ready is registered, so the first edge after reset
                // release raises it without accepting anything.
                cmd_ready_d = 1'b1;
                wdat_d      = 32'h0;
                if (cmd_valid_i && cmd_ready_o) begin
                    state_d     = BUS;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    sel_d       = cmd_sel_i;
                    wdat_d      = cmd_we_i ? cmd_dat_i : 32'h0;
`ifdef ONION_WB_MASTER_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            BUS: begin
                if (WBm_ACK_i) begin
                    // ACK takes priority over a coincident timeout.
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    wdat_d      = 32'h0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = WBm_WE_o ? 32'h0 : WBm_DAT_i;
`ifdef ONION_WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
`ifdef ONION_WB_MASTER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    wdat_d      = 32'h0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = WBm_WE_o ? 32'h0 : ERR_READ_VALUE;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b0;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                wdat_d      = 32'h0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_q        <= IDLE;
            cmd_ready_o    <= 1'b0;
            WBm_CYC_o      <= 1'b0;
            WBm_STB_o      <= 1'b0;
            WBm_WE_o       <= 1'b0;
            WBm_ADR_o      <= 17'h0;
            WBm_BYTE_STB_o <= 4'h0;
            WBm_DAT_o      <= 32'h0;
            rsp_valid_o    <= 1'b0;
            rsp_dat_o      <= 32'h0;
        end else begin
            state_q        <= state_d;
            cmd_ready_o    <= cmd_ready_d;
            WBm_CYC_o      <= cyc_d;
            WBm_STB_o      <= stb_d;
            WBm_WE_o       <= we_d;
            WBm_ADR_o      <= adr_d;
            WBm_BYTE_STB_o <= sel_d;
            WBm_DAT_o      <= wdat_d;
            rsp_valid_o    <= rsp_valid_d;
            rsp_dat_o      <= rsp_dat_d;
        end
    end

`ifdef ONION_WB_MASTER_TIMEOUT_EN
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            cnt_q     <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_o <= rsp_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_onion_wb_master.sv
// tb_onion_wb_master: directed stimulus, scoreboarded responses.
// A GPIO-style registered-ACK responder sits at 0x01000-0x01FFF.

module tb_onion_wb_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [16:0] cmd_adr_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic [16:0] WBm_ADR_o;
    logic        WBm_CYC_o;
    logic        WBm_STB_o;
    logic        WBm_WE_o;
    logic [3:0]  WBm_BYTE_STB_o;
    logic [31:0] WBm_DAT_o;
    logic [31:0] WBm_DAT_i;
    logic        WBm_ACK_i;

    always #5 clk = ~clk;

    onion_wb_master #(
        .TIMEOUT_CYCLES(16),
        .ERR_READ_VALUE(32'hDEAD_BEEF)
    ) dut (
        .WBs_CLK_i     (clk),
        .WBs_RST_n_i   (rst_n),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_we_i      (cmd_we_i),
        .cmd_adr_i     (cmd_adr_i),
        .cmd_sel_i     (cmd_sel_i),
        .cmd_dat_i     (cmd_dat_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_dat_o     (rsp_dat_o),
        .rsp_err_o     (rsp_err_o),
        .WBm_ADR_o     (WBm_ADR_o),
        .WBm_CYC_o     (WBm_CYC_o),
        .WBm_STB_o     (WBm_STB_o),
        .WBm_WE_o      (WBm_WE_o),
        .WBm_BYTE_STB_o(WBm_BYTE_STB_o),
        .WBm_DAT_o     (WBm_DAT_o),
        .WBm_DAT_i     (WBm_DAT_i),
        .WBm_ACK_i     (WBm_ACK_i)
    );

    // GPIO responder: registered single-cycle ACK, byte-lane writes.
    logic [31:0] mem [0:15];
    logic        ack_r = 1'b0;
    logic [31:0] rdat = '0;
    logic        force_ack = 1'b0;
    logic [31:0] force_dat = '0;
    logic        hit;

    assign hit = (WBm_ADR_o[16:12] == 5'h01);
    assign WBm_ACK_i = ack_r | force_ack;
    assign WBm_DAT_i = force_ack ? force_dat : rdat;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        ack_r <= 1'b0;
        if (WBm_CYC_o && WBm_STB_o && !ack_r && hit) begin
            ack_r <= 1'b1;
            if (WBm_WE_o) begin
                for (int b = 0; b < 4; b++)
                    if (WBm_BYTE_STB_o[b])
                        mem[WBm_ADR_o[5:2]][b*8 +: 8] <= WBm_DAT_o[b*8 +: 8];
            end else begin
                rdat <= mem[WBm_ADR_o[5:2]];
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   rsp_count = 0;

    // Response monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_dat", rsp_dat_o, e.dat);
                check("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
            end
            rsp_count++;
        end
    end

    // Bus monitor: STB occupancy and stability of the latched command.
    logic        exp_we = 1'b0;
    logic [16:0] exp_adr = '0;
    logic [3:0]  exp_sel = '0;
    logic [31:0] exp_wdat = '0;
    int          stb_hi_cnt = 0;
    int          stb_rises = 0;
    int          bus_bad = 0;
    logic        stb_prev = 1'b0;

    always @(negedge clk) begin
        if (WBm_STB_o) begin
            stb_hi_cnt++;
            if (!stb_prev) stb_rises++;
            if (!WBm_CYC_o || WBm_ADR_o !== exp_adr ||
                WBm_WE_o !== exp_we || WBm_BYTE_STB_o !== exp_sel ||
                WBm_DAT_o !== (exp_we ? exp_wdat : 32'h0))
                bus_bad++;
        end
        stb_prev = WBm_STB_o;
    end

    task automatic send(input logic we, input logic [16:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready_o) check("cmd_ready_wait", 32'd0, 32'd1);
        exp_we   = we;
        exp_adr  = adr;
        exp_sel  = sel;
        exp_wdat = dat;
        cmd_we_i  = we;
        cmd_adr_i = adr;
        cmd_sel_i = sel;
        cmd_dat_i = dat;
        cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        stb_hi_cnt = 0;
        stb_rises = 0;
        bus_bad = 0;
    endtask

    task automatic push(input logic [31:0] dat, input logic err);
        exp_t e;
        e.dat = dat;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp(input int prev);
        int n;
        n = 0;
        while (rsp_count == prev && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (rsp_count == prev) check("rsp_wait", 32'd0, 32'd1);
        #1;
    endtask

    task automatic gpio_txn(input string nm, input logic we,
                            input logic [16:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] rd);
        int prev;
        prev = rsp_count;
        push(we ? 32'h0 : rd, 1'b0);
        send(we, adr, sel, dat);
        wait_rsp(prev);
        check({nm, "_stb_rises"}, stb_rises, 32'd1);
        check({nm, "_stb_cycles"}, stb_hi_cnt, 32'd2);
        check({nm, "_bus_stable"}, bus_bad, 32'd0);
    endtask

    initial begin
        int prev;
        int bad;
        logic [31:0] held;

        // Reset state and ready rising one edge after release.
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
        check("rst_cyc_stb", {30'b0, WBm_CYC_o, WBm_STB_o}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_dat_o", WBm_DAT_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready_before_edge", {31'b0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        check("rel_ready_after_edge", {31'b0, cmd_ready_o}, 32'd1);

        // First write: also checks registered-ACK latency.
        prev = rsp_count;
        push(32'h0, 1'b0);
        send(1'b1, 17'h01004, 4'hF, 32'hA5A5_0F0F);
        @(negedge clk);
        check("lat_n_stb", {30'b0, WBm_STB_o, rsp_valid_o}, 32'd2);
        check("lat_n_ready", {31'b0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        check("lat_n1_ack", {30'b0, WBm_ACK_i, rsp_valid_o}, 32'd2);
        @(negedge clk);
        check("lat_n2_rsp", {30'b0, WBm_STB_o, rsp_valid_o}, 32'd1);
        wait_rsp(prev);
        check("wr1_stb_rises", stb_rises, 32'd1);
        check("wr1_bus_stable", bus_bad, 32'd0);
        @(negedge clk);
        check("idle_dat_o", WBm_DAT_o, 32'd0);

        gpio_txn("rd1", 1'b0, 17'h01004, 4'hF, 32'h0, 32'hA5A5_0F0F);
        gpio_txn("wr2", 1'b1, 17'h01004, 4'b0010, 32'h0000_3C00, 32'h0);
        gpio_txn("rd2", 1'b0, 17'h01004, 4'hF, 32'h0, 32'hA5A5_3C0F);

        // Response back-pressure held for 10 cycles.
        rsp_ready_i = 1'b0;
        prev = rsp_count;
        push(32'hA5A5_3C0F, 1'b0);
        send(1'b0, 17'h01004, 4'hF, 32'h0);
        bad = 0;
        while (!rsp_valid_o && bad < 50) begin
            @(negedge clk);
            bad++;
        end
        check("stall_valid", {31'b0, rsp_valid_o}, 32'd1);
        held = rsp_dat_o;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_dat_o !== held || cmd_ready_o ||
                WBm_STB_o)
                bad++;
        end
        check("stall_stable", bad, 32'd0);
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        wait_rsp(prev);

        // ACK outside a bus cycle is ignored.
        @(negedge clk);
        force_ack = 1'b1;
        force_dat = 32'h5555_AAAA;
        @(posedge clk);
        #1 force_ack = 1'b0;
        @(negedge clk);
        check("stray_ack", {29'b0, rsp_valid_o, cmd_ready_o, WBm_CYC_o},
              32'd2);

`ifdef ONION_WB_MASTER_TIMEOUT_EN
        // Timed-out read and write to an empty address.
        prev = rsp_count;
        push(32'hDEAD_BEEF, 1'b1);
        send(1'b0, 17'h02000, 4'hF, 32'h0);
        wait_rsp(prev);
        check("tmo_rd_stb_cycles", stb_hi_cnt, 32'd16);

        prev = rsp_count;
        push(32'h0, 1'b1);
        send(1'b1, 17'h02000, 4'hF, 32'h1111_2222);
        wait_rsp(prev);
        check("tmo_wr_stb_cycles", stb_hi_cnt, 32'd16);

        // ACK lands on the terminal-count cycle: ACK wins.
        prev = rsp_count;
        push(32'h1234_5678, 1'b0);
        send(1'b0, 17'h02000, 4'hF, 32'h0);
        bad = 0;
        while (stb_hi_cnt != 16 && bad < 40) begin
            @(negedge clk);
            #1;
            bad++;
        end
        force_dat = 32'h1234_5678;
        force_ack = 1'b1;
        @(posedge clk);
        #1 force_ack = 1'b0;
        wait_rsp(prev);
        check("ack_tc_stb_cycles", stb_hi_cnt, 32'd16);
`endif

        // Reset during a bus cycle drops the command silently.
        prev = rsp_count;
        send(1'b0, 17'h02000, 4'hF, 32'h0);
        repeat (3) @(negedge clk);
        check("midbus_stb", {31'b0, WBm_STB_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midbus_rst_async", {29'b0, WBm_CYC_o, WBm_STB_o, rsp_valid_o},
              32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midbus_ready_before", {31'b0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        check("midbus_ready_after", {31'b0, cmd_ready_o}, 32'd1);
        repeat (5) @(negedge clk);
        check("midbus_no_rsp", rsp_count - prev, 32'd0);

        // Bridge still works after the reset.
        gpio_txn("rd3", 1'b0, 17'h01004, 4'hF, 32'h0, 32'hA5A5_3C0F);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/onion_wb_master.md
ONION_WB_MASTER -- requirements
Module: onion_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: max cycles STB may wait for ACK before an error response.
REQ-002 SHALL have parameter ERR_READ_VALUE, default 32'hDEAD_BEEF: rsp_dat_o value on a timed-out read.
REQ-003 SHALL have port WBs_CLK_i  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port WBs_RST_n_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1, cmd_we_i in 1, cmd_adr_i in 17, cmd_sel_i in 4, cmd_dat_i in 32: the command channel (request, accept, write flag, byte address, byte strobes, write data).
REQ-006 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_dat_o out 32, rsp_err_o out 1: the response channel (valid, accept, read data, timeout flag).
REQ-007 SHALL have ports WBm_ADR_o out 17, WBm_CYC_o out 1, WBm_STB_o out 1, WBm_WE_o out 1, WBm_BYTE_STB_o out 4, WBm_DAT_o out 32, WBm_DAT_i in 32, WBm_ACK_i in 1: Wishbone initiator bus.

Function
REQ-008 SHALL implement FSM states IDLE, BUS, RESP; every output registered.
REQ-009 IDLE: cmd_ready_o=1; on cmd_valid_i&&cmd_ready_o at edge N, latch we/adr/sel/dat, go BUS, cmd_ready_o=0 from N.
REQ-010 BUS: WBm_CYC_o=WBm_STB_o=1 from edge N, ADR/WE/BYTE_STB/DAT_o held constant from latched command until the cycle ends.
REQ-011 BUS: on WBm_ACK_i sampled high, drop CYC/STB at that edge, capture WBm_DAT_i into rsp_dat_o for reads (rsp_dat_o=0 for writes), rsp_err_o=0, go RESP.
REQ-012 Latency against a registered-ACK responder: accept at N, STB high after N, ACK at N+1, rsp_valid_o after N+2.
REQ-013 BUS: wait counter resets to 0 on entry, increments each BUS cycle without ACK; at count TIMEOUT_CYCLES-1 with no ACK, drop CYC/STB, rsp_err_o=1, rsp_dat_o=ERR_READ_VALUE (reads) or 0 (writes), go RESP.
REQ-014 ACK and timeout terminal count in the same cycle: ACK wins, rsp_err_o=0.
REQ-015 RESP: rsp_valid_o=1, rsp_dat_o/rsp_err_o stable until rsp_valid_o&&rsp_ready_i; then IDLE, cmd_ready_o=1 next cycle (one command outstanding, no back-to-back overlap).
REQ-016 WBm_ACK_i high outside BUS SHALL be ignored; WBm_DAT_o SHALL be driven 0 during reads and in IDLE.
REQ-017 Counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits, no wrap before terminal count.

Reset
REQ-018 WBs_RST_n_i low SHALL immediately force IDLE, all outputs 0 (including cmd_ready_o, CYC, STB, rsp_valid_o), counter 0.
REQ-019 cmd_ready_o SHALL rise on the first clock edge after reset release.
REQ-020 Reset mid-BUS or mid-RESP SHALL discard the command with no response issued.

Configuration
REQ-021 Macro ONION_WB_MASTER_TIMEOUT_EN defined: timeout logic per REQ-013/014/017 compiled in.
REQ-022 Macro undefined: no counter, BUS waits indefinitely for ACK, rsp_err_o tied 0, TIMEOUT_CYCLES/ERR_READ_VALUE unused.

Verification
REQ-023 Write adr=17'h01004 sel=4'hF dat=32'hA5A5_0F0F to GPIO responder at 0x01000 -> one STB, ACK, rsp_valid_o with rsp_err_o=0, readback of 0x01004 returns 32'hA5A5_0F0F.
REQ-024 Write sel=4'b0010 dat=32'h0000_3C00 -> WBm_BYTE_STB_o=4'b0010 held through cycle; readback shows only byte 1 changed.
REQ-025 Read adr=17'h02000 (no responder), TIMEOUT_EN, TIMEOUT_CYCLES=16 -> STB high exactly 16 cycles, rsp_err_o=1, rsp_dat_o=32'hDEAD_BEEF.
REQ-026 ACK forced on cycle 16 of 16 -> rsp_err_o=0, rsp_dat_o=WBm_DAT_i value.
REQ-027 rsp_ready_i held low 10 cycles -> rsp_valid_o/rsp_dat_o stable, cmd_ready_o=0, no new STB.
REQ-028 Reset pulsed mid-BUS -> CYC/STB low asynchronously, no rsp_valid_o, cmd_ready_o=1 one edge after release.
